// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared ALU control codes, FSM encoding and width default
// ALUCtl values must stay in step with the control decoder.
package alu_defs;

   localparam int WIDTH_DEF = 32;

   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00001;
   localparam logic [4:0] ALU_ADD = 5'b00010;
   localparam logic [4:0] ALU_SUB = 5'b00110;
   localparam logic [4:0] ALU_SLT = 5'b00111;
   localparam logic [4:0] ALU_NOR = 5'b01100;
   localparam logic [4:0] ALU_XOR = 5'b01101;
   localparam logic [4:0] ALU_SLL = 5'b10000;
   localparam logic [4:0] ALU_SRL = 5'b11000;
   localparam logic [4:0] ALU_SRA = 5'b11001;
   localparam logic [4:0] ALU_MUL = 5'b11010;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } mul_state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// rtl/alu_seq_multiplier.sv - iterative shift-add multiplier, one partial product per cycle
// Signed operands are multiplied as magnitudes; the sign is reapplied on the final step.
module alu_seq_multiplier
   import alu_defs::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int MUL_ITERS = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(MUL_ITERS);
   localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

   mul_state_t       state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
   logic             neg;
   logic             accept;

   assign accept   = (state == ST_IDLE) && start && !flush;
   assign acc_step = acc + (mplier[0] ? mcand : '0);
   assign busy     = (state == ST_MUL);
   assign done     = (state == ST_MUL) && !flush && (count == LAST);
   assign product  = neg ? (~acc_step + 1'b1) : acc_step;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_MUL;
         ST_MUL:  if (flush || count == LAST) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Only the low WIDTH bits of the product are kept, so mcand may shift out freely.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         neg    <= 1'b0;
      end else if (accept) begin
         count  <= '0;
         mcand  <= (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
         mplier <= (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
         acc    <= '0;
         neg    <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state == ST_MUL && !flush) begin
         count  <= count + 1'b1;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         acc    <= acc_step;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU: single-cycle ops plus a 32-cycle sequential multiply
// Flush outranks both new work and a multiply completing on the same edge.
module alu_exec_unit
   import alu_defs::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int MUL_ITERS = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [4:0]       ALUCtl,
   input  logic             Sign,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             flush,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             out_valid,
   output logic             busy
);

   logic [WIDTH-1:0] op_result, mul_product;
   logic [4:0]       shamt;
   logic             is_mul, mul_start, mul_done, accept_single;

   assign shamt         = in1[4:0];
   assign is_mul        = (ALUCtl == ALU_MUL);
   assign mul_start     = in_valid && !busy && is_mul;
   assign accept_single = in_valid && !busy && !is_mul;
   assign zero          = (result == '0);

   alu_seq_multiplier #(
      .WIDTH     (WIDTH),
      .MUL_ITERS (MUL_ITERS)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .flush   (flush),
      .sign    (Sign),
      .a       (in1),
      .b       (in2),
      .busy    (busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      op_result = in1 + in2;
      case (ALUCtl)
         ALU_AND: op_result = in1 & in2;
         ALU_OR:  op_result = in1 | in2;
         ALU_ADD: op_result = in1 + in2;
         ALU_SUB: op_result = in1 - in2;
         ALU_SLT: op_result = Sign ? WIDTH'($signed(in1) < $signed(in2))
                                   : WIDTH'(in1 < in2);
         ALU_NOR: op_result = ~(in1 | in2);
         ALU_XOR: op_result = in1 ^ in2;
         ALU_SLL: op_result = in2 << shamt;
         ALU_SRL: op_result = in2 >> shamt;
         ALU_SRA: op_result = WIDTH'($signed(in2) >>> shamt);
         default: op_result = in1 + in2;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result    <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (mul_done) begin
         result    <= mul_product;
         out_valid <= 1'b1;
      end else if (accept_single) begin
         result    <= op_result;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule
